// File: rtl/board_pkg.sv
// Shared board definitions for the token movement path.
package board_pkg;

  localparam int unsigned TILE_MAX = 15;
  localparam int unsigned TILE_W   = 4;

  typedef logic [TILE_W-1:0] tile_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAND,
    ST_EVENT,
    ST_DONE,
    ST_WIN
  } move_state_t;

endpackage

// File: rtl/step_timer.sv
// Step interval counter: counts 0..STEP_CYCLES-1 while enabled, ticks on terminal count.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick_c = en && (count_q == TERM);

  // Next count: clear wins, otherwise wrap at the terminal count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick_c ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/token_move_sequencer.sv
// Walks one player's token tile by tile, holds on event tiles and flags a win.
module token_move_sequencer #(
  parameter int unsigned TILE_MAX    = board_pkg::TILE_MAX,
  parameter int unsigned STEP_CYCLES = 25_000_000,
  parameter logic [15:0] EVENT_MASK  = 16'h0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_req,
  input  logic       move_player,
  input  logic [2:0] move_steps,
  input  logic       event_end_tick,
  output logic       move_ack,
  output logic       busy,
  output logic [3:0] p1_pos,
  output logic [3:0] p2_pos,
  output logic       pos_valid,
  output logic       event_flag,
  output logic       turn_done,
  output logic       winner_valid,
  output logic       winner_id
);

  import board_pkg::tile_t;
  import board_pkg::move_state_t;
  import board_pkg::ST_IDLE;
  import board_pkg::ST_WAIT;
  import board_pkg::ST_LAND;
  import board_pkg::ST_EVENT;
  import board_pkg::ST_DONE;
  import board_pkg::ST_WIN;

  localparam tile_t LAST_TILE = tile_t'(TILE_MAX);

  move_state_t state_q, state_d;
  logic        player_q, player_d;
  logic [2:0]  steps_left_q, steps_left_d;
  tile_t       p1_pos_q, p1_pos_d;
  tile_t       p2_pos_q, p2_pos_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        pos_valid_q, pos_valid_d;
  logic        event_flag_q, event_flag_d;
  logic        turn_done_q, turn_done_d;
  logic        winner_valid_q, winner_valid_d;
  logic        winner_id_q, winner_id_d;
  // Set when DONE was entered from EVENT: the completion pulse was already issued.
  logic        evt_exit_q, evt_exit_d;

  logic        timer_en_c;
  logic        timer_clr_c;
  logic        timer_tick_c;
  tile_t       cur_pos_c;
  tile_t       next_pos_c;

  assign cur_pos_c  = player_q ? p2_pos_q : p1_pos_q;
  assign next_pos_c = cur_pos_c + tile_t'(1);

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (timer_en_c),
    .clr    (timer_clr_c),
    .tick_c (timer_tick_c)
  );

  // Next-state, request latch, position update and registered-output logic.
  always_comb begin
    state_d        = state_q;
    player_d       = player_q;
    steps_left_d   = steps_left_q;
    p1_pos_d       = p1_pos_q;
    p2_pos_d       = p2_pos_q;
    ack_d          = 1'b0;
    busy_d         = (state_q != ST_IDLE);
    pos_valid_d    = 1'b0;
    event_flag_d   = (state_q == ST_EVENT);
    turn_done_d    = (state_q == ST_DONE) && !evt_exit_q;
    winner_valid_d = winner_valid_q;
    winner_id_d    = winner_id_q;
    evt_exit_d     = 1'b0;
    timer_en_c     = (state_q == ST_WAIT);
    timer_clr_c    = 1'b0;

    if (new_game) begin
      state_d        = ST_IDLE;
      player_d       = 1'b0;
      steps_left_d   = 3'd0;
      p1_pos_d       = '0;
      p2_pos_d       = '0;
      busy_d         = 1'b0;
      event_flag_d   = 1'b0;
      turn_done_d    = 1'b0;
      winner_valid_d = 1'b0;
      winner_id_d    = 1'b0;
      timer_en_c     = 1'b0;
      timer_clr_c    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (move_req && !winner_valid_q) begin
            player_d     = move_player;
            steps_left_d = move_steps;
            ack_d        = 1'b1;
            timer_clr_c  = 1'b1;
            state_d      = (move_steps == 3'd0) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (timer_tick_c) begin
            timer_clr_c  = 1'b1;
            pos_valid_d  = 1'b1;
            steps_left_d = steps_left_q - 3'd1;
            if (player_q) begin
              p2_pos_d = next_pos_c;
            end else begin
              p1_pos_d = next_pos_c;
            end
            if (next_pos_c == LAST_TILE) begin
              state_d        = ST_WIN;
              winner_valid_d = 1'b1;
              winner_id_d    = player_q;
            end else if (steps_left_q == 3'd1) begin
              state_d = ST_LAND;
            end
          end
        end
        ST_LAND: begin
          state_d = EVENT_MASK[cur_pos_c] ? ST_EVENT : ST_DONE;
        end
        ST_EVENT: begin
          if (event_end_tick) begin
            state_d      = ST_DONE;
            turn_done_d  = 1'b1;
            event_flag_d = 1'b0;
            evt_exit_d   = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        ST_WIN: begin
          state_d = ST_WIN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      player_q       <= 1'b0;
      steps_left_q   <= 3'd0;
      p1_pos_q       <= '0;
      p2_pos_q       <= '0;
      ack_q          <= 1'b0;
      busy_q         <= 1'b0;
      pos_valid_q    <= 1'b0;
      event_flag_q   <= 1'b0;
      turn_done_q    <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_id_q    <= 1'b0;
      evt_exit_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      player_q       <= player_d;
      steps_left_q   <= steps_left_d;
      p1_pos_q       <= p1_pos_d;
      p2_pos_q       <= p2_pos_d;
      ack_q          <= ack_d;
      busy_q         <= busy_d;
      pos_valid_q    <= pos_valid_d;
      event_flag_q   <= event_flag_d;
      turn_done_q    <= turn_done_d;
      winner_valid_q <= winner_valid_d;
      winner_id_q    <= winner_id_d;
      evt_exit_q     <= evt_exit_d;
    end
  end

  assign move_ack     = ack_q;
  assign busy         = busy_q;
  assign p1_pos       = p1_pos_q;
  assign p2_pos       = p2_pos_q;
  assign pos_valid    = pos_valid_q;
  assign event_flag   = event_flag_q;
  assign turn_done    = turn_done_q;
  assign winner_valid = winner_valid_q;
  assign winner_id    = winner_id_q;

endmodule

// File: tb/tb_token_move_sequencer.sv
// Scoreboard bench for token_move_sequencer (STEP_CYCLES=4, event tile 5).
module tb_token_move_sequencer;

  localparam int STEP = 4;
  localparam int EV_ACK  = 0;
  localparam int EV_POS  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       move_req;
  logic       move_player;
  logic [2:0] move_steps;
  logic       event_end_tick;
  logic       move_ack;
  logic       busy;
  logic [3:0] p1_pos;
  logic [3:0] p2_pos;
  logic       pos_valid;
  logic       event_flag;
  logic       turn_done;
  logic       winner_valid;
  logic       winner_id;

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];
  logic [3:0] m_p1 = 4'd0;
  logic [3:0] m_p2 = 4'd0;
  logic [15:0] ev_mask = 16'h0020;
  int         a;
  int         u;
  int         n;

  token_move_sequencer #(
    .TILE_MAX    (15),
    .STEP_CYCLES (STEP),
    .EVENT_MASK  (16'h0020)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .new_game       (new_game),
    .move_req       (move_req),
    .move_player    (move_player),
    .move_steps     (move_steps),
    .event_end_tick (event_end_tick),
    .move_ack       (move_ack),
    .busy           (busy),
    .p1_pos         (p1_pos),
    .p2_pos         (p2_pos),
    .pos_valid      (pos_valid),
    .event_flag     (event_flag),
    .turn_done      (turn_done),
    .winner_valid   (winner_valid),
    .winner_id      (winner_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  function automatic int pk(input logic wv, input logic wid);
    return int'({wv, wid, m_p1, m_p2});
  endfunction

  function automatic void exp_push(input int kind, input int c, input int v);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Drop expectations for cycles after an abort.
  function automatic void prune(input int last);
    exp_t tmp[$];
    foreach (exp_q[i]) if (exp_q[i].cyc <= last) tmp.push_back(exp_q[i]);
    exp_q = tmp;
  endfunction

  task automatic match_ev(input int kind, input int val);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexp_ev", kind, 32'hFF);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cyc", cyc, e.cyc);
      check("ev_val", val, e.val);
    end
  endtask

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (move_ack === 1'b1)  match_ev(EV_ACK,  int'({winner_valid, winner_id, p1_pos, p2_pos}));
    if (pos_valid === 1'b1) match_ev(EV_POS,  int'({winner_valid, winner_id, p1_pos, p2_pos}));
    if (turn_done === 1'b1) match_ev(EV_DONE, int'({winner_valid, winner_id, p1_pos, p2_pos}));
  end

  task automatic step_to(input int c);
    if (cyc > c) check("sched", cyc, c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a one-cycle request and push the events the move should produce.
  task automatic do_move(input logic pl, input int st, output int a_o, output int u_o);
    logic [3:0] np;
    bit stop;
    move_player = pl;
    move_steps  = 3'(st);
    move_req    = 1'b1;
    a_o  = cyc + 1;
    u_o  = a_o;
    stop = 1'b0;
    exp_push(EV_ACK, a_o, pk(1'b0, 1'b0));
    for (int k = 1; k <= st; k++) begin
      if (!stop) begin
        np = (pl ? m_p2 : m_p1) + 4'd1;
        if (pl) m_p2 = np; else m_p1 = np;
        u_o = a_o + k * STEP;
        if (np == 4'd15) begin
          exp_push(EV_POS, u_o, pk(1'b1, pl));
          stop = 1'b1;
        end else begin
          exp_push(EV_POS, u_o, pk(1'b0, 1'b0));
        end
      end
    end
    if (st == 0) begin
      exp_push(EV_DONE, a_o + 1, pk(1'b0, 1'b0));
    end else if (!stop && !ev_mask[pl ? m_p2 : m_p1]) begin
      exp_push(EV_DONE, u_o + 2, pk(1'b0, 1'b0));
    end
    @(posedge clk);
    #1;
    move_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; new_game = 1'b0; move_req = 1'b0;
    move_player = 1'b0; move_steps = 3'd0; event_end_tick = 1'b0;

    // Reset state
    step_to(2);
    check("rst_p1", p1_pos, 0);
    check("rst_p2", p2_pos, 0);
    check("rst_busy", busy, 0);
    check("rst_wv", winner_valid, 0);
    check("rst_ef", event_flag, 0);
    check("rst_pulses", {move_ack, pos_valid, turn_done}, 0);
    reset = 1'b1;
    step_to(4);

    // P1 three steps, plain landing
    do_move(1'b0, 3, a, u);
    step_to(u + 2); check("busy_u2", busy, 1);
    step_to(u + 3); check("busy_u3", busy, 0);
    check("p2_still", p2_pos, 0);

    // P2 to tile 3 with stray request and stray event end during WAIT
    step_to(u + 5);
    do_move(1'b1, 3, a, u);
    step_to(a + 2); move_req = 1'b1; move_player = 1'b0; move_steps = 3'd7;
    step_to(a + 3); move_req = 1'b0;
    step_to(a + 5); event_end_tick = 1'b1;
    step_to(a + 6); event_end_tick = 1'b0;
    step_to(u + 3); check("p2_at3", p2_pos, 3);

    // P2 lands on event tile 5
    do_move(1'b1, 2, a, u);
    step_to(u + 1); check("ef_u1", event_flag, 0);
    step_to(u + 2); check("ef_u2", event_flag, 1);
    step_to(u + 12);
    exp_push(EV_DONE, u + 13, pk(1'b0, 1'b0));
    event_end_tick = 1'b1;
    step_to(u + 13); event_end_tick = 1'b0;
    check("ef_e1", event_flag, 0);
    step_to(u + 16); check("busy_evt", busy, 0);

    // P1 to 13, then a four-step request that wins at 15
    do_move(1'b0, 7, a, u);
    step_to(u + 4);
    do_move(1'b0, 3, a, u);
    step_to(u + 4);
    check("p1_at13", p1_pos, 13);
    do_move(1'b0, 4, a, u);
    step_to(a + 7); check("wv_pre", winner_valid, 0);
    step_to(a + 8);
    check("wv_win", winner_valid, 1);
    check("wid_win", winner_id, 0);
    check("p1_win", p1_pos, 15);
    step_to(a + 20); move_req = 1'b1; move_player = 1'b1; move_steps = 3'd1;
    step_to(a + 21); move_req = 1'b0;
    step_to(a + 32);
    check("wv_sticky", winner_valid, 1);
    check("pending_win", exp_q.size(), 0);

    // New game clears the board; a same-cycle request is dropped
    n = cyc; new_game = 1'b1;
    step_to(n + 1); new_game = 1'b0;
    m_p1 = 4'd0; m_p2 = 4'd0;
    check("ng_p1", p1_pos, 0);
    check("ng_p2", p2_pos, 0);
    check("ng_wv", winner_valid, 0);
    n = cyc; new_game = 1'b1; move_req = 1'b1; move_player = 1'b0; move_steps = 3'd2;
    step_to(n + 1); new_game = 1'b0; move_req = 1'b0;
    step_to(n + 6); check("ng_req_busy", busy, 0);

    // Abort a P2 move one cycle after its first step
    do_move(1'b1, 3, a, u);
    step_to(a + 5); new_game = 1'b1;
    step_to(a + 6); new_game = 1'b0;
    prune(a + 5);
    m_p1 = 4'd0; m_p2 = 4'd0;
    check("abort_p2", p2_pos, 0);
    check("abort_busy", busy, 0);
    step_to(a + 30);
    check("pending_abort", exp_q.size(), 0);

    // Zero-step move
    do_move(1'b0, 0, a, u);
    step_to(a + 3);
    check("zero_busy", busy, 0);
    check("pending_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
